// File: rtl/dly_ctrl_pkg.sv
// Shared types and field positions for the delay-load controller.
// Broadcast loads are enabled by defining DELAY_LOAD_BCAST_EN.
package dly_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam int CMD_TOG_BIT = 31;
  localparam int CMD_CLR_BIT = 30;
  localparam int CMD_CH_MSB  = 27;
  localparam int CMD_CH_LSB  = 24;

  localparam int STS_RANGE_BIT = 31;
  localparam int STS_TO_BIT    = 30;
  localparam int STS_OVR_BIT   = 29;
  localparam int STS_BUSY_BIT  = 28;
  localparam int STS_CNT_W     = 16;

  localparam logic [3:0] BCAST_CH = 4'hF;

endpackage

// File: rtl/delay_load_ctrl.sv
// Software-command driven loader for per-channel delay values.
// Define DELAY_LOAD_BCAST_EN to make channel 0xF load every channel.
module delay_load_ctrl
  import dly_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DELAY_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        user_data_in,
  output logic [3:0]         dly_load_ch,
  output logic [DELAY_W-1:0] dly_load_val,
  output logic               dly_load_req,
  input  logic               dly_load_ack,
  output logic               busy,
  output logic [31:0]        status_out
);

  localparam logic [3:0]  LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

  logic [31:0]        data_q;
  logic               tog_hist;
  logic               evt_q;
  logic               cmd_clr;
  logic [3:0]         cmd_ch;
  logic [DELAY_W-1:0] cmd_val;
  logic               unused_data;

  state_e             state;
  logic [15:0]        tmr;
  logic               bcast;
  logic               err_range;
  logic               err_timeout;
  logic               err_overrun;
  logic [15:0]        load_count;

  assign unused_data = ^data_q;

  // Input register, toggle edge detect and command capture.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      data_q   <= user_data_in;
      tog_hist <= user_data_in[CMD_TOG_BIT];
      evt_q    <= 1'b0;
      cmd_clr  <= 1'b0;
      cmd_ch   <= '0;
      cmd_val  <= '0;
    end else begin
      data_q   <= user_data_in;
      tog_hist <= data_q[CMD_TOG_BIT];
      evt_q    <= data_q[CMD_TOG_BIT] ^ tog_hist;
      cmd_clr  <= data_q[CMD_CLR_BIT];
      cmd_ch   <= data_q[CMD_CH_MSB:CMD_CH_LSB];
      cmd_val  <= data_q[DELAY_W-1:0];
    end
  end

  // Load sequencer with inline ack timeout and sticky error flags.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state        <= ST_IDLE;
      dly_load_req <= 1'b0;
      dly_load_ch  <= '0;
      dly_load_val <= '0;
      busy         <= 1'b0;
      tmr          <= '0;
      bcast        <= 1'b0;
      err_range    <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      load_count   <= '0;
    end else begin
      // Clear first so an error from this same command still lands.
      if (evt_q && cmd_clr) begin
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (evt_q && state != ST_IDLE)
        err_overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (evt_q) begin
            dly_load_ch  <= cmd_ch;
            dly_load_val <= cmd_val;
            busy         <= 1'b1;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          tmr <= '0;
`ifdef DELAY_LOAD_BCAST_EN
          if (dly_load_ch == BCAST_CH) begin
            bcast        <= 1'b1;
            dly_load_ch  <= '0;
            dly_load_req <= 1'b1;
            state        <= ST_REQ;
          end else
`endif
          if (dly_load_ch <= LAST_CH) begin
            dly_load_req <= 1'b1;
            state        <= ST_REQ;
          end else begin
            err_range <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dly_load_ack) begin
            dly_load_req <= 1'b0;
            state        <= ST_DONE;
          end else if (tmr == TMR_LAST) begin
            dly_load_req <= 1'b0;
            err_timeout  <= 1'b1;
            bcast        <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_DONE: begin
          load_count <= load_count + 16'd1;
          if (bcast && dly_load_ch != LAST_CH) begin
            dly_load_ch  <= dly_load_ch + 4'd1;
            dly_load_req <= 1'b1;
            tmr          <= '0;
            state        <= ST_REQ;
          end else begin
            bcast <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign status_out = {err_range, err_timeout, err_overrun, busy,
                       12'b0, load_count};

endmodule

// File: doc/delay_load_ctrl.md
DELAY_LOAD_CTRL -- requirements
Module: delay_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of delay channels (1..15).
REQ-002 SHALL have parameter DELAY_W, default 16, delay value width (1..24).
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles to wait for an ack before aborting (1..65535).
REQ-004 SHALL have port user_clk, input, 1, the only clock.
REQ-005 SHALL have port user_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port user_data_in, input, 32, command word from the software register, already in the user_clk domain.
REQ-007 SHALL have port dly_load_ch, output, 4, target channel index.
REQ-008 SHALL have port dly_load_val, output, DELAY_W, delay value to load.
REQ-009 SHALL have port dly_load_req, output, 1, load request to the delay datapath.
REQ-010 SHALL have port dly_load_ack, input, 1, load accepted by the datapath.
REQ-011 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-012 SHALL have port status_out, output, 32, status word for the readback register: {err_range, err_timeout, err_overrun, busy, 12'b0, load_count[15:0]}.

Function
REQ-013 SHALL decode the command word as: bit31 = command toggle, bit30 = clear errors, bits27:24 = channel, bits DELAY_W-1:0 = value.
REQ-014 SHALL register user_data_in every cycle.
REQ-015 SHALL treat a change of registered bit31 versus its previous registered value as one command event.
REQ-016 SHALL use states IDLE, CHECK, REQ, DONE.
- On an event in IDLE: latch channel and value, go to CHECK.
- CHECK: go to REQ if channel < NUM_CH, else set err_range and go to IDLE.
- REQ: hold req high until ack is sampled high, then go to DONE.
- DONE: increment load_count, go to IDLE.
REQ-017 SHALL assert dly_load_req exactly 3 cycles after the edge on which the new user_data_in is presented (input register, edge detect, CHECK).
REQ-018 SHALL hold dly_load_ch and dly_load_val stable while dly_load_req is high.
REQ-019 SHALL deassert dly_load_req in the cycle after ack is sampled high.
REQ-020 SHALL accept an ack that is present in the same cycle req first rises.
REQ-021 SHALL, if ack is not seen within TIMEOUT cycles of req rising, drop req, set err_timeout, skip the load_count increment, and return to IDLE.
REQ-022 SHALL, on an event arriving while not in IDLE, drop the event and set err_overrun.
REQ-023 SHALL, on an event whose bit30 is 1, clear all three error flags in the event cycle.
- An error raised by that same command is set after the clear.
REQ-024 SHALL make load_count a 16-bit counter that wraps from 0xFFFF to 0x0000.
REQ-025 SHALL keep error flags sticky until cleared or reset.

Reset
REQ-026 SHALL, while user_rst is high at a clock edge, drive: state IDLE, req 0, ch 0, val 0, busy 0, all error flags 0, load_count 0, status_out 0.
REQ-027 SHALL preload the toggle history from the current user_data_in bit31 on reset, so no spurious event occurs after reset.
REQ-028 SHALL, on reset during REQ, drop req on the next cycle and ignore any ack that arrives later.

Configuration
REQ-029 SHALL support macro DELAY_LOAD_BCAST_EN.
- Defined: channel 0xF is a broadcast; REQ runs once per channel from 0 to NUM_CH-1 with the same value; each completed load increments load_count; a timeout aborts the remaining channels.
- Not defined: channel 0xF is out of range and sets err_range.

Structure
REQ-030 SHALL place in shared package dly_ctrl_pkg: the state enum, the command bit-position constants, and the status-field positions.
REQ-031 SHALL contain no sub-module; the timeout counter and FSM are inline.

Verification
REQ-032 SHALL cover a basic load.
- Stimulus: word 0x8300_0123, ack held high.
- Response: req rises after 3 cycles with ch=3, val=0x0123; req lasts 1 cycle; load_count=1.
REQ-033 SHALL cover a range error.
- Stimulus: NUM_CH=8, word toggled with ch=9.
- Response: no req; status bit31=1.
REQ-034 SHALL cover a timeout.
- Stimulus: TIMEOUT=4, ack held low.
- Response: req is high for exactly 4 cycles; err_timeout=1; load_count unchanged.
REQ-035 SHALL cover overrun and clear.
- Stimulus: toggle again while busy.
- Response: err_overrun=1.
- Stimulus: then a toggle with bit30=1.
- Response: all error flags 0.
REQ-036 SHALL cover broadcast.
- Stimulus: DELAY_LOAD_BCAST_EN defined, NUM_CH=4, ch=0xF, val=0x55, ack delayed 2 cycles.
- Response: four requests to ch 0,1,2,3; load_count=4.
REQ-037 SHALL cover counter wrap and reset.
- Stimulus: load_count preloaded to 0xFFFF by forcing, then one load.
- Response: load_count=0x0000.
- Stimulus: user_rst asserted mid-REQ.
- Response: req=0 next cycle; no event generated after release.
